// File: rtl/serial_word_collector_if.sv
// Bit-level input side and word-level output side of the serial word collector.
interface serial_word_collector_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             a;
  logic             b;
  logic             c;
  logic             f_ready;
  logic [WIDTH-1:0] f;
  logic [CNT_W-1:0] g;
  logic             f_valid;

  modport master (output a, b, c, f_ready, input f, g, f_valid);
  modport slave  (input a, b, c, f_ready, output f, g, f_valid);
endinterface

// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector: f_valid rises on the edge sampling the completing strobe (1 cycle);
// a word completing while f is held (f_valid && !f_ready) is dropped and sets sticky overflow.
module serial_word_collector #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  serial_word_collector_if.slave  bus,
  output logic                    overflow
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  // cnt doubles as the collector state: 0 is IDLE, anything else is COLLECT
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       out_state;

  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] word_dat;
  logic [CNT_W-1:0] word_cnt;
  logic             complete;
  logic             can_load;
  logic             drain;

  generate
    if (MSB_FIRST) begin : g_msb
      assign acc_shift = {acc[WIDTH-2:0], bus.a};
    end else begin : g_lsb
      // bits above cnt are always zero, so OR-ing places a at acc[cnt]
      assign acc_shift = acc | (WIDTH'(bus.a) << cnt);
    end
  endgenerate

  always_comb begin
    word_dat = acc;
    word_cnt = cnt;
    if (bus.b) begin
      word_dat = acc_shift;
      word_cnt = cnt + CNT_W'(1);
    end
    complete = (bus.b && (bus.c || (cnt == CNT_W'(WIDTH - 1))))
             || (!bus.b && bus.c && (cnt != '0));
    can_load = (out_state == OUT_EMPTY) || bus.f_ready;
    drain    = (out_state == OUT_FULL) && bus.f_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_state <= OUT_EMPTY;
      bus.f     <= '0;
      bus.g     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (complete) begin
        acc <= '0;
        cnt <= '0;
      end else if (bus.b) begin
        acc <= acc_shift;
        cnt <= word_cnt;
      end

      if (complete && can_load) begin
        bus.f     <= word_dat;
        bus.g     <= word_cnt;
        out_state <= OUT_FULL;
      end else if (drain) begin
        out_state <= OUT_EMPTY;
      end

      // a drop in the same cycle as clr wins
      if (complete && !can_load) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.f_valid = (out_state == OUT_FULL);
endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Parametrised serial-to-parallel collector that assembles single-bit strobed input (`a` data, `b` strobe, `c` frame-last) into a `WIDTH`-bit output word `f` with bit count `g`. Sits between bit-level input pins and word-level consumers. It generalises fixed 4-bit `f`/`g` port bundles to configurable width, bit order, early frame termination, a valid/ready output handshake and overflow reporting.

## Interface
- `WIDTH`, default 4: output word width in bits, ≥ 2.
- `MSB_FIRST`, default 0: 0 = first received bit lands in `f[0]`; 1 = first received bit ends up most significant of the received bits.
- `CNT_W`, derived localparam: `$clog2(WIDTH+1)`, not overridable.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input 1: serial data bit, sampled when `b`=1.
- `b` input 1: bit strobe.
- `c` input 1: frame-last; terminates the current word.
- `clr` input 1: synchronous clear of `overflow`.
- `f_ready` input 1: consumer accepts `f` when `f_valid && f_ready`.
- `f` output WIDTH: assembled word, right-aligned, unfilled bits zero.
- `g` output CNT_W: number of valid bits in `f`, 1..WIDTH.
- `f_valid` output 1: `f`/`g` hold a word.
- `overflow` output 1: sticky; set when a completed word is dropped.

## Operation
- Internal accumulator `acc[WIDTH]` and count `cnt[CNT_W]`.
- Collector FSM states:
  - IDLE (`cnt`=0).
  - COLLECT (0<`cnt`<WIDTH).
- Output register: EMPTY (`f_valid`=0) or FULL (`f_valid`=1).
- Bit accept, `b`=1:
  - `MSB_FIRST`=0: `acc[cnt]<=a`.
  - `MSB_FIRST`=1: `acc<={acc[WIDTH-2:0],a}`.
  - `cnt` increments; IDLE→COLLECT.
- Word complete when either:
  - `b`=1 and `cnt`=WIDTH-1, or
  - `b`=1 and `c`=1 at any `cnt`, or
  - `b`=0, `c`=1 and `cnt`>0 (flush partial word, `g`=`cnt`).
- `c`=1, `b`=0, `cnt`=0: ignored.
- On completion, the word (including the current bit) loads into `f`/`g` if the output is EMPTY or drains this cycle (`f_valid && f_ready`). Otherwise the word is dropped and `overflow`<=1.
- On completion, `acc` and `cnt` always clear to 0 (back to IDLE), whether the word was loaded or dropped.
- Drain with no load: `f_valid`<=0; `f`/`g` may keep their stale value.
- `f`/`g` stay stable while `f_valid && !f_ready`.
- `clr`=1 clears `overflow`. If `clr` and a drop occur in the same cycle, `overflow` ends at 1.

## Timing
- Reset (async assert, synchronous-safe release):
  - `f`=0, `g`=0, `f_valid`=0, `overflow`=0.
  - `acc`=0, `cnt`=0.
  - A partial word in progress is discarded.
- Latency: `f_valid` rises on the clock edge that samples the completing strobe (1 cycle).
- Throughput: one bit per cycle. With `f_ready`=1 held, back-to-back words sustain continuous `f_valid`=1 for WIDTH=1-cycle bursts; for WIDTH≥2, `f_valid` pulses 1 cycle per word.
- Drain and load in the same cycle: `f_valid` stays 1 and `f`/`g` take the new word; no bubble, no overflow.
- `a` is don't-care when `b`=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All cases use WIDTH=4.
- LSB-first (`MSB_FIRST`=0): strobes a=1,0,1,1, `f_ready`=1 → after 4th edge `f`=4'b1101, `g`=4, `f_valid`=1 for one cycle.
- MSB-first (`MSB_FIRST`=1): same stimulus → `f`=4'b1011, `g`=4.
- Partial and idle flush:
  - Strobes a=1,1, then `c`=1 with `b`=0 → `f`=4'b0011, `g`=2.
  - A further lone `c` → no `f_valid`.
  - `b`=1, `c`=1, a=1 at `cnt`=0 → `f`=4'b0001, `g`=1.
- Backpressure: `f_ready`=0, feed words 0xA then 0x5 →
  - `f`=0xA held.
  - 0x5 dropped; `overflow`=1 on its completion edge.
  - Pulse `clr` → `overflow`=0.
  - Raise `f_ready` → 0xA accepted, `f_valid`=0.
- Simultaneous: `f_valid`=1 holding 0x3, `f_ready`=1 on the same cycle a new word 0xC completes → `f`=0xC, `f_valid` stays 1, `overflow`=0.
- Reset mid-frame: 2 bits strobed, assert `rst_n`=0 asynchronously (between edges) → all outputs 0 immediately; after release, strobes 0,1,1,0 → `f`=4'b0110, `g`=4.
